// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cam_pkg
// Brief    : Shared types and helpers for the OV7670 capture front end:
//            output-format encodings, capture state enum, RGB565 converter.
// Revision : 1.0 - initial release
// ============================================================================
package cam_pkg;

  localparam logic [1:0] FMT_RGB332 = 2'd0;
  localparam logic [1:0] FMT_RGB444 = 2'd1;
  localparam logic [1:0] FMT_RGB565 = 2'd2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    ACTIVE     = 2'd2
  } state_t;

  // Result is right-justified; the caller keeps the low OUT_W bits.
  function automatic logic [15:0] rgb565_convert(input logic [1:0] fmt,
                                                 input logic [15:0] p);
    logic [15:0] r;
    case (fmt)
      FMT_RGB332: r = {8'h00, p[15:13], p[10:8], p[4:3]};
      FMT_RGB444: r = {4'h0, p[15:12], p[10:7], p[4:1]};
      default:    r = p;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cam_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : cam_sync_edge
// Brief    : W-bit two-flop synchroniser with optional third stage and
//            registered rise/fall pulses (EDGE=1). With EDGE=0 only the
//            synchronised level is produced.
// Revision : 1.0 - initial release
// ============================================================================
module cam_sync_edge #(
  parameter int W    = 1,
  parameter bit EDGE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_rise,
  output logic [W-1:0] o_fall
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  // Synchroniser flops are left unreset so a reset never fabricates an edge.
  always_ff @(posedge clk) begin
    r_s1 <= i_d;
    r_s2 <= r_s1;
  end

  generate
    if (EDGE) begin : g_edge
      logic [W-1:0] r_s3;
      logic [W-1:0] r_rise;
      logic [W-1:0] r_fall;

      // Third stage plus registered edge pulses; o_q aligns with the pulses.
      always_ff @(posedge clk) begin
        r_s3 <= r_s2;
        if (rst) begin
          r_rise <= '0;
          r_fall <= '0;
        end else begin
          r_rise <= r_s2 & ~r_s3;
          r_fall <= ~r_s2 & r_s3;
        end
      end

      assign o_q    = r_s3;
      assign o_rise = r_rise;
      assign o_fall = r_fall;
    end else begin : g_level
      logic w_unused_rst;
      assign w_unused_rst = rst;
      assign o_q    = r_s2;
      assign o_rise = '0;
      assign o_fall = '0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/ov7670_capture.sv
`default_nettype none
// ============================================================================
// Module   : ov7670_capture
// Brief    : OV7670 capture front end in the system clock domain. Samples the
//            camera pins, assembles RGB565 pixels, decimates, converts and
//            emits frame-buffer writes with frame tracking and error flag.
// Revision : 1.0 - initial release
// ============================================================================
module ov7670_capture
  import cam_pkg::*;
#(
  parameter int WIDTH     = 176,
  parameter int HEIGHT    = 144,
  parameter int ADDR_W    = 15,
  parameter int OUT_FMT   = 0,
  parameter int OUT_W     = 8,
  parameter int DECIM     = 1,
  parameter int BYTE_SWAP = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              PCLK,
  input  logic              HREF,
  input  logic              VSYNC,
  input  logic [7:0]        CAM_DATA,
  input  logic              ENABLE,
  input  logic              SINGLE_SHOT,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [OUT_W-1:0]  W_DATA,
  output logic              W_EN,
  output logic              FRAME_DONE,
  output logic              FRAME_ERR,
  output logic              BUSY
);

  localparam logic [11:0]       c_WIDTH   = 12'(WIDTH);
  localparam logic [11:0]       c_HEIGHT  = 12'(HEIGHT);
  localparam logic [11:0]       c_DMASK   = 12'(DECIM - 1);
  localparam logic [ADDR_W-1:0] c_WIDTH_A = ADDR_W'(WIDTH);

  generate
    if (!((OUT_FMT == 0 && OUT_W == 8) || (OUT_FMT == 1 && OUT_W == 12) ||
          (OUT_FMT == 2 && OUT_W == 16))) begin : g_bad_fmt
      $error("ov7670_capture: OUT_W does not match OUT_FMT");
    end
    if (!(DECIM == 1 || DECIM == 2 || DECIM == 4)) begin : g_bad_decim
      $error("ov7670_capture: DECIM must be 1, 2 or 4");
    end
    if (WIDTH * HEIGHT > (2 ** ADDR_W)) begin : g_bad_addr
      $error("ov7670_capture: ADDR_W too small for WIDTH*HEIGHT");
    end
  endgenerate

  // Control pins: bit 2 = PCLK, bit 1 = HREF, bit 0 = VSYNC.
  logic [2:0] w_ctrl_q, w_ctrl_rise, w_ctrl_fall;
  logic [7:0] w_data_q, w_data_rise, w_data_fall;

  cam_sync_edge #(.W(3), .EDGE(1'b1)) u_ctrl_sync (
    .clk   (CLK),
    .rst   (RESET),
    .i_d   ({PCLK, HREF, VSYNC}),
    .o_q   (w_ctrl_q),
    .o_rise(w_ctrl_rise),
    .o_fall(w_ctrl_fall)
  );

  cam_sync_edge #(.W(8), .EDGE(1'b0)) u_data_sync (
    .clk   (CLK),
    .rst   (RESET),
    .i_d   (CAM_DATA),
    .o_q   (w_data_q),
    .o_rise(w_data_rise),
    .o_fall(w_data_fall)
  );

  logic w_pclk_rise, w_href_q, w_href_fall, w_vs_rise, w_vs_fall;
  assign w_pclk_rise = w_ctrl_rise[2];
  assign w_href_q    = w_ctrl_q[1];
  assign w_href_fall = w_ctrl_fall[1];
  assign w_vs_rise   = w_ctrl_rise[0];
  assign w_vs_fall   = w_ctrl_fall[0];

  state_t            r_state, w_state_nxt;
  logic              w_frame_start, w_frame_end;
  logic              r_phase, r_line_kept, r_err, r_wen, r_done, r_busy;
  logic [7:0]        r_byte0;
  logic [11:0]       r_src_x, r_src_line, r_x, r_y;
  logic [ADDR_W-1:0] r_addr, r_line_base, r_waddr;
  logic [OUT_W-1:0]  r_wdata;
  logic [15:0]       w_pixel, w_conv;
  logic              w_keep;

  assign w_pixel = (BYTE_SWAP != 0) ? {w_data_q, r_byte0} : {r_byte0, w_data_q};
  assign w_conv  = rgb565_convert(2'(OUT_FMT), w_pixel);
  assign w_keep  = ((r_src_x & c_DMASK) == 12'd0) && ((r_src_line & c_DMASK) == 12'd0);

  logic w_unused;
  assign w_unused = &{1'b0, w_ctrl_q, w_ctrl_rise, w_ctrl_fall,
                      w_data_rise, w_data_fall, w_conv};

  // Capture state register.
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state plus frame start/end strobes for the datapath.
  always_comb begin
    w_state_nxt   = r_state;
    w_frame_start = 1'b0;
    w_frame_end   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_vs_rise && ENABLE) w_state_nxt = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (w_vs_fall) begin
          w_state_nxt   = ACTIVE;
          w_frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (w_vs_rise) begin
          w_frame_end = 1'b1;
          w_state_nxt = (SINGLE_SHOT || !ENABLE) ? IDLE : WAIT_FRAME;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Byte assembly, decimation, bounds checking and write generation.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_phase     <= 1'b0;
      r_line_kept <= 1'b0;
      r_err       <= 1'b0;
      r_wen       <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_byte0     <= '0;
      r_src_x     <= '0;
      r_src_line  <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_addr      <= '0;
      r_line_base <= '0;
      r_waddr     <= '0;
      r_wdata     <= '0;
    end else begin
      r_wen  <= 1'b0;
      r_done <= w_frame_end;
      r_busy <= (w_state_nxt != IDLE);
      if (w_frame_start) begin
        r_phase     <= 1'b0;
        r_line_kept <= 1'b0;
        r_err       <= 1'b0;
        r_src_x     <= '0;
        r_src_line  <= '0;
        r_x         <= '0;
        r_y         <= '0;
        r_addr      <= '0;
        r_line_base <= '0;
      end else if (w_frame_end) begin
        // A frame cut mid-line or with the wrong line count is flagged.
        r_phase <= 1'b0;
        if (r_phase || w_href_q || (r_y != c_HEIGHT)) r_err <= 1'b1;
      end else if (r_state == ACTIVE) begin
        if (w_href_fall) begin
          // Odd trailing byte is dropped by clearing the phase.
          r_phase     <= 1'b0;
          r_src_x     <= '0;
          r_src_line  <= r_src_line + 12'd1;
          r_x         <= '0;
          r_line_kept <= 1'b0;
          if (r_line_kept) begin
            r_y         <= r_y + 12'd1;
            r_line_base <= r_line_base + c_WIDTH_A;
            r_addr      <= r_line_base + c_WIDTH_A;
            if (r_x != c_WIDTH) r_err <= 1'b1;
          end
        end else if (w_pclk_rise && w_href_q) begin
          if (!r_phase) begin
            r_byte0 <= w_data_q;
            r_phase <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            r_src_x <= r_src_x + 12'd1;
            if (w_keep) begin
              r_x         <= r_x + 12'd1;
              r_line_kept <= 1'b1;
              if ((r_x < c_WIDTH) && (r_y < c_HEIGHT)) begin
                r_wen   <= 1'b1;
                r_waddr <= r_addr;
                r_wdata <= w_conv[OUT_W-1:0];
                r_addr  <= r_addr + ADDR_W'(1);
              end else begin
                r_err <= 1'b1;
              end
            end
          end
        end
      end
    end
  end

  assign W_ADDR     = r_waddr;
  assign W_DATA     = r_wdata;
  assign W_EN       = r_wen;
  assign FRAME_DONE = r_done;
  assign FRAME_ERR  = r_err;
  assign BUSY       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ov7670_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_ov7670_capture
// Brief    : Directed bench for ov7670_capture. Three instances share the
//            camera pins: A (RGB332, 6x3), B (RGB565, byte swap, DECIM 2,
//            3x2 from a 6x3 camera), C (RGB444, byte swap, 6x3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ov7670_capture;

  logic       clk = 1'b0, rst = 1'b1;
  logic       pclk = 1'b0, href = 1'b0, vsync = 1'b0;
  logic       ena = 1'b0, single = 1'b0;
  logic [7:0] cam = 8'h00;

  logic [4:0]  addr_a; logic [7:0]  data_a; logic wen_a, done_a, err_a, busy_a;
  logic [3:0]  addr_b; logic [15:0] data_b; logic wen_b, done_b, err_b, busy_b;
  logic [4:0]  addr_c; logic [11:0] data_c; logic wen_c, done_c, err_c, busy_c;

  always #5 clk = ~clk;

  ov7670_capture #(.WIDTH(6), .HEIGHT(3), .ADDR_W(5), .OUT_FMT(0), .OUT_W(8),
                   .DECIM(1), .BYTE_SWAP(0)) dut_a (
    .CLK(clk), .RESET(rst), .PCLK(pclk), .HREF(href), .VSYNC(vsync),
    .CAM_DATA(cam), .ENABLE(ena), .SINGLE_SHOT(single),
    .W_ADDR(addr_a), .W_DATA(data_a), .W_EN(wen_a),
    .FRAME_DONE(done_a), .FRAME_ERR(err_a), .BUSY(busy_a));

  ov7670_capture #(.WIDTH(3), .HEIGHT(2), .ADDR_W(4), .OUT_FMT(2), .OUT_W(16),
                   .DECIM(2), .BYTE_SWAP(1)) dut_b (
    .CLK(clk), .RESET(rst), .PCLK(pclk), .HREF(href), .VSYNC(vsync),
    .CAM_DATA(cam), .ENABLE(ena), .SINGLE_SHOT(single),
    .W_ADDR(addr_b), .W_DATA(data_b), .W_EN(wen_b),
    .FRAME_DONE(done_b), .FRAME_ERR(err_b), .BUSY(busy_b));

  ov7670_capture #(.WIDTH(6), .HEIGHT(3), .ADDR_W(5), .OUT_FMT(1), .OUT_W(12),
                   .DECIM(1), .BYTE_SWAP(1)) dut_c (
    .CLK(clk), .RESET(rst), .PCLK(pclk), .HREF(href), .VSYNC(vsync),
    .CAM_DATA(cam), .ENABLE(ena), .SINGLE_SHOT(single),
    .W_ADDR(addr_c), .W_DATA(data_c), .W_EN(wen_c),
    .FRAME_DONE(done_c), .FRAME_ERR(err_c), .BUSY(busy_c));

  // Write logs and event counters gathered away from the active edge.
  logic [15:0] log_addr_a [0:255], log_data_a [0:255];
  logic [15:0] log_addr_b [0:255], log_data_b [0:255];
  logic [15:0] log_addr_c [0:255], log_data_c [0:255];
  int cnt_a = 0, cnt_b = 0, cnt_c = 0, ndone_a = 0, ncoinc = 0;

  always @(negedge clk) begin
    if (wen_a) begin
      log_addr_a[cnt_a] <= 16'(addr_a);
      log_data_a[cnt_a] <= 16'(data_a);
      cnt_a <= cnt_a + 1;
    end
    if (wen_b) begin
      log_addr_b[cnt_b] <= 16'(addr_b);
      log_data_b[cnt_b] <= data_b;
      cnt_b <= cnt_b + 1;
    end
    if (wen_c) begin
      log_addr_c[cnt_c] <= 16'(addr_c);
      log_data_c[cnt_c] <= 16'(data_c);
      cnt_c <= cnt_c + 1;
    end
    if (done_a) ndone_a <= ndone_a + 1;
    if ((wen_a && done_a) || (wen_b && done_b) || (wen_c && done_c))
      ncoinc <= ncoinc + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    cam  = b;
    pclk = 1'b0;
    wait_clk(3);
    pclk = 1'b1;
    wait_clk(3);
  endtask

  task automatic send_line(input int npix, input logic [7:0] b0, input logic [7:0] b1);
    href = 1'b1;
    for (int i = 0; i < npix; i++) begin
      send_byte(b0);
      send_byte(b1);
    end
    pclk = 1'b0;
    wait_clk(3);
    href = 1'b0;
    wait_clk(8);
  endtask

  task automatic vs_rise();
    vsync = 1'b1;
    wait_clk(8);
  endtask

  task automatic vs_fall();
    vsync = 1'b0;
    wait_clk(8);
  endtask

  // Compare a range of logged writes against an address ramp and fixed data.
  task automatic chk_log(input string tag, input int dut, input int first,
                         input int n, input logic [15:0] exp_data);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      case (dut)
        0: if (log_addr_a[first+i] !== 16'(i) || log_data_a[first+i] !== exp_data) bad++;
        1: if (log_addr_b[first+i] !== 16'(i) || log_data_b[first+i] !== exp_data) bad++;
        default: if (log_addr_c[first+i] !== 16'(i) || log_data_c[first+i] !== exp_data) bad++;
      endcase
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state.
    wait_clk(4);
    rst = 1'b0;
    wait_clk(1);
    chk("rst_waddr", 32'(addr_a), 32'd0);
    chk("rst_wdata", 32'(data_a), 32'd0);
    chk("rst_wen",   32'(wen_a),  32'd0);
    chk("rst_done",  32'(done_a), 32'd0);
    chk("rst_err",   32'(err_a),  32'd0);
    chk("rst_busy",  32'(busy_a), 32'd0);

    // Frame 1: bytes F8,1F everywhere.
    ena = 1'b1;
    vs_rise();
    chk("f1_busy_wait", 32'(busy_a), 32'd1);
    vs_fall();
    send_line(6, 8'hF8, 8'h1F);
    send_line(6, 8'hF8, 8'h1F);
    chk("f1_b_skip_line1", 32'(cnt_b), 32'd3);
    send_line(6, 8'hF8, 8'h1F);
    vs_rise();
    chk("f1_done",  32'(ndone_a), 32'd1);
    chk("f1_cnt_a", 32'(cnt_a), 32'd18);
    chk("f1_cnt_b", 32'(cnt_b), 32'd6);
    chk("f1_cnt_c", 32'(cnt_c), 32'd18);
    chk("f1_err_a", 32'(err_a), 32'd0);
    chk("f1_err_b", 32'(err_b), 32'd0);
    chk("f1_err_c", 32'(err_c), 32'd0);
    chk_log("f1_log_a", 0, 0, 18, 16'h00E3);
    chk_log("f1_log_b", 1, 0, 6,  16'h1FF8);
    chk_log("f1_log_c", 2, 0, 18, 16'h01FC);
    chk("f1_busy_cont", 32'(busy_a), 32'd1);
    vs_fall();

    // Frame 2: bytes 1F,F8 everywhere.
    for (int l = 0; l < 3; l++) send_line(6, 8'h1F, 8'hF8);
    vs_rise();
    chk("f2_cnt_a", 32'(cnt_a), 32'd36);
    chk("f2_cnt_b", 32'(cnt_b), 32'd12);
    chk_log("f2_log_a", 0, 18, 18, 16'h001F);
    chk_log("f2_log_b", 1, 6,  6,  16'hF81F);
    chk_log("f2_log_c", 2, 18, 18, 16'h0F0F);
    chk("f2_err_a", 32'(err_a), 32'd0);
    vs_fall();

    // Frame 3: short middle line and an overlong last line.
    send_line(6, 8'hF8, 8'h1F);
    send_line(5, 8'hF8, 8'h1F);
    chk("f3_err_a_short", 32'(err_a), 32'd1);
    chk("f3_err_c_short", 32'(err_c), 32'd1);
    chk("f3_err_b_skipped", 32'(err_b), 32'd0);
    send_line(7, 8'hF8, 8'h1F);
    vs_rise();
    chk("f3_cnt_a", 32'(cnt_a), 32'd53);
    chk("f3_line2_addr", 32'(log_addr_a[47]), 32'd12);
    chk("f3_last_addr", 32'(log_addr_a[52]), 32'd17);
    chk("f3_cnt_b", 32'(cnt_b), 32'd18);
    chk("f3_err_b_long", 32'(err_b), 32'd1);
    chk("f3_err_a_end", 32'(err_a), 32'd1);
    chk("f3_done", 32'(ndone_a), 32'd3);

    // Frame 4: single shot, then camera keeps running with capture disabled.
    single = 1'b1;
    vs_fall();
    chk("f4_err_cleared", 32'(err_a), 32'd0);
    for (int l = 0; l < 3; l++) send_line(6, 8'hF8, 8'h1F);
    vs_rise();
    chk("f4_done", 32'(ndone_a), 32'd4);
    chk("f4_busy_idle", 32'(busy_a), 32'd0);
    chk("f4_cnt_a", 32'(cnt_a), 32'd71);
    ena = 1'b0;
    vs_fall();
    for (int f = 0; f < 2; f++) begin
      for (int l = 0; l < 3; l++) send_line(6, 8'hF8, 8'h1F);
      vs_rise();
      vs_fall();
    end
    chk("ss_no_writes", 32'(cnt_a), 32'd71);
    chk("ss_no_done", 32'(ndone_a), 32'd4);
    chk("ss_busy", 32'(busy_a), 32'd0);

    // Reset in the middle of a line, then resume at the next frame.
    ena    = 1'b1;
    single = 1'b0;
    vs_rise();
    vs_fall();
    href = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_byte(8'hF8);
      send_byte(8'h1F);
    end
    send_byte(8'hF8);
    chk("mid_cnt_a", 32'(cnt_a), 32'd74);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    chk("mid_rst_wen", 32'(wen_a), 32'd0);
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    send_byte(8'h1F);
    for (int i = 0; i < 2; i++) begin
      send_byte(8'hF8);
      send_byte(8'h1F);
    end
    pclk = 1'b0;
    wait_clk(3);
    href = 1'b0;
    wait_clk(8);
    chk("post_rst_no_writes", 32'(cnt_a), 32'd74);
    vs_rise();
    vs_fall();
    send_line(6, 8'hF8, 8'h1F);
    chk("resume_cnt", 32'(cnt_a), 32'd80);
    chk("resume_addr0", 32'(log_addr_a[74]), 32'd0);
    chk("resume_addr5", 32'(log_addr_a[79]), 32'd5);
    vs_rise();
    chk("final_done", 32'(ndone_a), 32'd5);
    chk("done_wen_overlap", 32'(ncoinc), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
